// File: rtl/prf_pkg.sv
// Shared constants, types and the write-port priority pick for the physical
// register file / ready scoreboard.
package prf_pkg;

  localparam int NUM_REGS_DEF  = 32;
  localparam int WIDTH_DEF     = 16;
  localparam int NUM_RD_DEF    = 8;
  localparam int NUM_WR_DEF    = 4;
  localparam int NUM_ALLOC_DEF = 2;
  localparam int AW_DEF        = $clog2(NUM_REGS_DEF);

  // Upper bound on write ports the priority pick can arbitrate.
  localparam int MAX_WR = 16;

  typedef logic [AW_DEF-1:0]    preg_t;
  typedef logic [WIDTH_DEF-1:0] word_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } pick_t;

  // Highest-index set bit wins, matching the array's write priority.
  function automatic pick_t highest_match(input logic [MAX_WR-1:0] match);
    pick_t p;
    p = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (match[i]) begin
        p.hit = 1'b1;
        p.idx = i[3:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/prf_fwd_mux.sv
// Per-read-port forward select: same-cycle write data and ready set/clear
// override the stored register, register 0 is forced to 0/ready.
module prf_fwd_mux #(
  parameter int WIDTH     = 16,
  parameter int AW        = 5,
  parameter int NUM_WR    = 4,
  parameter int NUM_ALLOC = 2
) (
  input  logic [AW-1:0]                   rd_addr,
  input  logic [WIDTH-1:0]                mem_data,
  input  logic                            mem_ready,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]       wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]    wr_data,
  input  logic [NUM_ALLOC-1:0]            alloc_en,
  input  logic [NUM_ALLOC-1:0][AW-1:0]    alloc_addr,
  output logic [WIDTH-1:0]                fwd_data,
  output logic                            fwd_ready
);
  import prf_pkg::*;

  logic [MAX_WR-1:0] match;
  logic              alloc_hit;
  pick_t             pick;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    match     = '0;
    alloc_hit = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      match[w] = wr_en[w] && (wr_addr[w] == rd_addr);
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_en[a] && (alloc_addr[a] == rd_addr)) alloc_hit = 1'b1;
    end
    pick = highest_match(match);

    fwd_data = mem_data;
    for (int w = 0; w < NUM_WR; w++) begin
      if (pick.hit && (int'(pick.idx) == w)) fwd_data = wr_data[w];
    end
    // Alloc clear beats write set: the register now belongs to a new producer.
    fwd_ready = alloc_hit ? 1'b0 : (pick.hit ? 1'b1 : mem_ready);

    if (rd_addr == '0) begin
      fwd_data  = '0;
      fwd_ready = 1'b1;
    end
  end

endmodule

// File: rtl/prf_scoreboard.sv
// Multi-port physical register file with integrated ready scoreboard,
// registered read ports with internal forwarding, and sticky collision flag.
module prf_scoreboard #(
  parameter  int NUM_REGS  = 32,
  parameter  int WIDTH     = 16,
  parameter  int NUM_RD    = 8,
  parameter  int NUM_WR    = 4,
  parameter  int NUM_ALLOC = 2,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD-1:0][AW-1:0]       rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_ready,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]       wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]    wr_data,
  input  logic [NUM_ALLOC-1:0]            alloc_en,
  input  logic [NUM_ALLOC-1:0][AW-1:0]    alloc_addr,
  output logic                            wr_collision
);

  logic [WIDTH-1:0]              mem_q [NUM_REGS];
  logic [WIDTH-1:0]              mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]           ready_q, ready_d;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]             rd_ready_q, rd_ready_d;
  logic                          wr_collision_q, wr_collision_d;

  // Writes in ascending port order so the highest-index port lands last;
  // allocs follow so their clear overrides a same-cycle write's set.
  always_comb begin
    mem_d          = mem_q;
    ready_d        = ready_q;
    wr_collision_d = wr_collision_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w] != '0)) begin
        mem_d[wr_addr[w]]   = wr_data[w];
        ready_d[wr_addr[w]] = 1'b1;
      end
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_en[a] && (alloc_addr[a] != '0)) ready_d[alloc_addr[a]] = 1'b0;
    end
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p] == wr_addr[q]) && (wr_addr[p] != '0))
          wr_collision_d = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    prf_fwd_mux #(
      .WIDTH     (WIDTH),
      .AW        (AW),
      .NUM_WR    (NUM_WR),
      .NUM_ALLOC (NUM_ALLOC)
    ) u_fwd (
      .rd_addr    (rd_addr[i]),
      .mem_data   (mem_q[rd_addr[i]]),
      .mem_ready  (ready_q[rd_addr[i]]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .fwd_data   (rd_data_d[i]),
      .fwd_ready  (rd_ready_d[i])
    );
  end

  // NOTE: the register array is a flop array that must come up as zero, so
  // it is reset like any other state rather than left to a memory macro.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q          <= '{default: '0};
      ready_q        <= '1;
      rd_data_q      <= '0;
      rd_ready_q     <= '1;
      wr_collision_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      ready_q        <= ready_d;
      rd_data_q      <= rd_data_d;
      rd_ready_q     <= rd_ready_d;
      wr_collision_q <= wr_collision_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_ready     = rd_ready_q;
  assign wr_collision = wr_collision_q;

endmodule

// File: tb/tb_prf_scoreboard.sv
// Self-checking bench for prf_scoreboard: directed scenarios plus randomized
// traffic against a sequential register/ready model.
module tb_prf_scoreboard;
  import prf_pkg::*;

  localparam int NR = NUM_REGS_DEF;
  localparam int W  = WIDTH_DEF;
  localparam int RD = NUM_RD_DEF;
  localparam int WR = NUM_WR_DEF;
  localparam int AL = NUM_ALLOC_DEF;
  localparam int A  = AW_DEF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [RD-1:0][A-1:0]  rd_addr;
  logic [RD-1:0][W-1:0]  rd_data;
  logic [RD-1:0]         rd_ready;
  logic [WR-1:0]         wr_en;
  logic [WR-1:0][A-1:0]  wr_addr;
  logic [WR-1:0][W-1:0]  wr_data;
  logic [AL-1:0]         alloc_en;
  logic [AL-1:0][A-1:0]  alloc_addr;
  logic                  wr_collision;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state
  word_t m_mem [NR];
  logic  m_rdy [NR];
  logic  m_coll;
  word_t exp_data  [RD];
  logic  exp_ready [RD];

  prf_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .alloc_en     (alloc_en),
    .alloc_addr   (alloc_addr),
    .wr_collision (wr_collision)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_mem[r] = '0;
      m_rdy[r] = 1'b1;
    end
    m_coll = 1'b0;
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = '0; alloc_addr = '0;
  endtask

  // Predict reads from pre-edge state, then apply the cycle to the model, then clock.
  task automatic clock_cycle();
    int cnt [NR];
    for (int i = 0; i < RD; i++) begin
      int a;
      logic whit, ahit;
      a = int'(rd_addr[i]);
      whit = 1'b0; ahit = 1'b0;
      exp_data[i] = m_mem[a];
      for (int w = WR - 1; w >= 0; w--) begin
        if (!whit && wr_en[w] && int'(wr_addr[w]) == a) begin
          exp_data[i] = wr_data[w];
          whit = 1'b1;
        end
      end
      for (int k = 0; k < AL; k++) if (alloc_en[k] && int'(alloc_addr[k]) == a) ahit = 1'b1;
      exp_ready[i] = ahit ? 1'b0 : (whit ? 1'b1 : m_rdy[a]);
      if (a == 0) begin exp_data[i] = '0; exp_ready[i] = 1'b1; end
    end
    for (int r = 0; r < NR; r++) cnt[r] = 0;
    for (int w = 0; w < WR; w++) begin
      if (wr_en[w] && wr_addr[w] != 0) begin
        m_mem[wr_addr[w]] = wr_data[w];
        m_rdy[wr_addr[w]] = 1'b1;
        cnt[wr_addr[w]]++;
      end
    end
    for (int k = 0; k < AL; k++) if (alloc_en[k] && alloc_addr[k] != 0) m_rdy[alloc_addr[k]] = 1'b0;
    for (int r = 1; r < NR; r++) if (cnt[r] > 1) m_coll = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #12;
    n_vec++;
    if (rd_data !== '0 || rd_ready !== '1 || wr_collision !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_outputs: rd_data=%h rd_ready=%b coll=%b, want 0/all-ones/0",
               rd_data, rd_ready, wr_collision);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < RD; i++) rd_addr[i] = A'(i);
    clock_cycle();
    for (int i = 0; i < RD; i++) begin
      n_vec++;
      if (rd_data[i] !== '0 || rd_ready[i] !== 1'b1) begin
        n_miss++;
        $display("FAIL reset_read[%0d]: data=%h ready=%b, want 0000/1", i, rd_data[i], rd_ready[i]);
      end
    end
    n_vec++;
    if (wr_collision !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_coll: got %b want 0", wr_collision);
    end
  endtask

  task automatic test_write_fwd();
    idle();
    wr_en[2] = 1'b1; wr_addr[2] = 5'd5; wr_data[2] = 16'hBEEF;
    rd_addr[0] = 5'd5;
    clock_cycle();
    n_vec++;
    if (rd_data[0] !== 16'hBEEF || rd_ready[0] !== 1'b1) begin
      n_miss++;
      $display("FAIL fwd_r5: data=%h ready=%b, want BEEF/1", rd_data[0], rd_ready[0]);
    end
    idle();
    clock_cycle();
    rd_addr[3] = 5'd5;
    clock_cycle();
    n_vec++;
    if (rd_data[3] !== 16'hBEEF || rd_ready[3] !== 1'b1) begin
      n_miss++;
      $display("FAIL reread_r5: data=%h ready=%b, want BEEF/1", rd_data[3], rd_ready[3]);
    end
  endtask

  task automatic test_r0();
    idle();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 16'hFFFF;
    wr_en[1] = 1'b1; wr_addr[1] = 5'd0; wr_data[1] = 16'hFFFF;
    alloc_en[0] = 1'b1; alloc_addr[0] = 5'd0;
    rd_addr[1] = 5'd0;
    clock_cycle();
    n_vec++;
    if (rd_data[1] !== '0 || rd_ready[1] !== 1'b1 || wr_collision !== 1'b0) begin
      n_miss++;
      $display("FAIL r0_same_cycle: data=%h ready=%b coll=%b, want 0000/1/0",
               rd_data[1], rd_ready[1], wr_collision);
    end
    idle();
    rd_addr[6] = 5'd0;
    clock_cycle();
    n_vec++;
    if (rd_data[6] !== '0 || rd_ready[6] !== 1'b1 || wr_collision !== 1'b0) begin
      n_miss++;
      $display("FAIL r0_later: data=%h ready=%b coll=%b, want 0000/1/0",
               rd_data[6], rd_ready[6], wr_collision);
    end
  endtask

  task automatic test_alloc();
    idle();
    alloc_en[1] = 1'b1; alloc_addr[1] = 5'd12;
    clock_cycle();
    idle();
    rd_addr[2] = 5'd12;
    clock_cycle();
    n_vec++;
    if (rd_ready[2] !== 1'b0) begin
      n_miss++;
      $display("FAIL alloc_clear: ready=%b want 0", rd_ready[2]);
    end
    idle();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd12; wr_data[0] = 16'h00A5;
    clock_cycle();
    idle();
    rd_addr[4] = 5'd12;
    clock_cycle();
    n_vec++;
    if (rd_data[4] !== 16'h00A5 || rd_ready[4] !== 1'b1) begin
      n_miss++;
      $display("FAIL write_sets_ready: data=%h ready=%b, want 00A5/1", rd_data[4], rd_ready[4]);
    end
    idle();
    wr_en[3] = 1'b1; wr_addr[3] = 5'd12; wr_data[3] = 16'h5A5A;
    alloc_en[0] = 1'b1; alloc_addr[0] = 5'd12;
    rd_addr[7] = 5'd12;
    clock_cycle();
    n_vec++;
    if (rd_data[7] !== 16'h5A5A || rd_ready[7] !== 1'b0) begin
      n_miss++;
      $display("FAIL alloc_beats_write_fwd: data=%h ready=%b, want 5A5A/0", rd_data[7], rd_ready[7]);
    end
    idle();
    rd_addr[5] = 5'd12;
    clock_cycle();
    n_vec++;
    if (rd_data[5] !== 16'h5A5A || rd_ready[5] !== 1'b0) begin
      n_miss++;
      $display("FAIL alloc_beats_write_stored: data=%h ready=%b, want 5A5A/0", rd_data[5], rd_ready[5]);
    end
  endtask

  task automatic test_collision();
    idle();
    wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 16'h1111;
    wr_en[3] = 1'b1; wr_addr[3] = 5'd9; wr_data[3] = 16'h3333;
    rd_addr[2] = 5'd9;
    clock_cycle();
    n_vec++;
    if (rd_data[2] !== 16'h3333 || wr_collision !== 1'b1) begin
      n_miss++;
      $display("FAIL collision_fwd: data=%h coll=%b, want 3333/1", rd_data[2], wr_collision);
    end
    idle();
    rd_addr[0] = 5'd9;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd10; wr_data[0] = 16'h0101;
    clock_cycle();
    n_vec++;
    if (rd_data[0] !== 16'h3333 || wr_collision !== 1'b1) begin
      n_miss++;
      $display("FAIL collision_stored: data=%h coll=%b, want 3333/1", rd_data[0], wr_collision);
    end
    idle();
    wr_en[2] = 1'b1; wr_addr[2] = 5'd11; wr_data[2] = 16'h0202;
    clock_cycle();
    n_vec++;
    if (wr_collision !== 1'b1) begin
      n_miss++;
      $display("FAIL collision_sticky: coll=%b want 1", wr_collision);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < RD; i++) rd_addr[i] = A'($urandom_range(0, NR - 1));
    for (int w = 0; w < WR; w++) begin
      wr_en[w]   = ($urandom_range(0, 3) != 0);
      wr_addr[w] = A'($urandom_range(0, 15));
      wr_data[w] = W'($urandom);
    end
    for (int k = 0; k < AL; k++) begin
      alloc_en[k]   = ($urandom_range(0, 2) == 0);
      alloc_addr[k] = A'($urandom_range(0, 15));
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      randomize_inputs();
      clock_cycle();
      for (int i = 0; i < RD; i++) begin
        n_vec++;
        if (rd_data[i] !== exp_data[i] || rd_ready[i] !== exp_ready[i]) begin
          n_miss++;
          $display("FAIL random c%0d port%0d: data=%h ready=%b, want %h/%b",
                   c, i, rd_data[i], rd_ready[i], exp_data[i], exp_ready[i]);
        end
      end
      n_vec++;
      if (wr_collision !== m_coll) begin
        n_miss++;
        $display("FAIL random c%0d coll: got %b want %b", c, wr_collision, m_coll);
      end
    end
  endtask

  task automatic test_async_reset();
    randomize_inputs();
    clock_cycle();
    randomize_inputs();
    wr_en = '1;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (rd_data !== '0 || rd_ready !== '1 || wr_collision !== 1'b0) begin
      n_miss++;
      $display("FAIL async_reset: rd_data=%h rd_ready=%b coll=%b, want 0/all-ones/0",
               rd_data, rd_ready, wr_collision);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int blk = 0; blk < NR / RD; blk++) begin
      for (int i = 0; i < RD; i++) rd_addr[i] = A'(blk * RD + i);
      clock_cycle();
      for (int i = 0; i < RD; i++) begin
        n_vec++;
        if (rd_data[i] !== '0 || rd_ready[i] !== 1'b1) begin
          n_miss++;
          $display("FAIL post_reset r%0d: data=%h ready=%b, want 0000/1",
                   blk * RD + i, rd_data[i], rd_ready[i]);
        end
      end
    end
    n_vec++;
    if (wr_collision !== 1'b0) begin
      n_miss++;
      $display("FAIL post_reset coll: got %b want 0", wr_collision);
    end
  endtask

  initial begin
    test_reset();
    test_write_fwd();
    test_r0();
    test_alloc();
    test_collision();
    test_random(300);
    test_async_reset();
    idle();
    test_random(100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
